evt_barrier_ctrl: RTL
=====================

Name: evt_barrier_ctrl

Overview:
- Controller that sequences an N-channel event-stream synchronizer.
- Drives the synchronizer's per-channel synch-enable and forward-barrier controls.
- Per barrier round: gathers the time barriers (EVT_TIME operation) from all active channels, then releases exactly one barrier downstream (leader, round-robin) or all of them.
- Sits next to the synchronizer; upstream-stall timeout plus status counters are exposed to the config/status register file.

Parameters:
- N, 4, number of event channels (≥2)
- TW, 16, width of the timeout threshold and timeout counter
- CW, 16, width of the completed-barrier counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ctrl_en_i  in  1  controller enable (config register)
- chan_mask_i  in  N  channels participating in synchronization
- fwd_all_i  in  1  0: forward leader barrier only; 1: forward barrier on every active channel
- timeout_i  in  TW  cycles allowed from first to last barrier arrival; 0 disables timeout
- clr_i  in  1  clears sticky timeout state and re-admits dropped channels
- barrier_i  in  N  per channel: synchronizer input valid AND operation==EVT_TIME
- barrier_hs_i  in  N  per channel: synchronizer output valid&ready carrying EVT_TIME
- synch_en_o  out  N  to synchronizer synch_en
- fwd_barrier_o  out  N  to synchronizer fwd_barrier
- barrier_cnt_o  out  CW  completed barrier rounds, wraps
- timeout_o  out  1  one-cycle pulse on timeout
- timeout_chan_o  out  N  sticky: channels dropped by timeout
- busy_o  out  1  high in COLLECT while any active barrier is pending, and throughout RELEASE

Behaviour:
- Reset values: all outputs 0; FSM IDLE; leader pointer ptr 0; active mask 0; drop mask 0; timeout counter 0.
- active = latched chan_mask_i & ~drop.
- Latch points for active: entry to COLLECT, and every exit from RELEASE.

FSM states:
- IDLE
  - Outputs: synch_en_o=0, fwd_barrier_o=0.
  - ctrl_en_i=1 → COLLECT next cycle.
- COLLECT
  - Outputs: synch_en_o=active, fwd_barrier_o=0.
  - arr = barrier_i & active.
  - Timeout counter: cleared while arr==0; otherwise increments once per cycle, saturating.
  - Release condition: arr==active and active≠0 → RELEASE.
  - Leader is computed on that transition: first set bit of active scanning ptr, ptr+1, … cyclically mod N; latched.
  - Timeout condition: timeout_i≠0, counter==timeout_i, and release condition false. Then:
    - drop |= active & ~arr; timeout_chan_o |= same bits; timeout_o pulses 1 cycle;
    - active reduced the next cycle; counter cleared;
    - if any arrived channels remain, the release condition is re-evaluated on the reduced mask.
  - active==0: stay in COLLECT, counter held at 0, busy_o=0.
  - ctrl_en_i=0 → IDLE next cycle; counter cleared.
- RELEASE
  - synch_en_o holds the active value latched at entry.
  - Forward set F = fwd_all_i ? active : onehot(leader); fwd_barrier_o=F. fwd_all_i is sampled at entry.
  - done |= barrier_hs_i & F each cycle.
  - Exit condition: (done | (barrier_hs_i & F)) == F. On exit:
    - barrier_cnt_o++ (wraps mod 2^CW); ptr = (leader+1) mod N; done cleared;
    - go to COLLECT if ctrl_en_i=1, else IDLE.
  - ctrl_en_i is ignored for the duration of RELEASE; the round always completes.
- Latency:
  - Last barrier arrival cycle t → fwd_barrier_o asserted at t+1.
  - Handshake at cycle u completing F → COLLECT (fwd_barrier_o=0) at u+1.
- clr_i:
  - Clears drop and timeout_chan_o the next cycle, in any state.
  - The new active takes effect at the next latch point.
  - If clr_i coincides with a timeout in the same cycle, the timeout wins for the newly dropped bits.
- chan_mask_i changes during COLLECT/RELEASE are ignored until the next latch point.
- Timeout is never evaluated in RELEASE.

Test Plan:
- N=4, mask=4'b1111, fwd_all=0, barrier_i bits arrive at cycles 2,3,5,6 → fwd_barrier_o=4'b0001 at cycle 7; barrier_hs_i[0] at 9 → barrier_cnt_o=1, COLLECT at 10.
- Three consecutive rounds as above → leaders 0,1,2 (fwd_barrier_o 0001,0010,0100); with mask=4'b1010, leaders alternate 0010, 1000.
- fwd_all=1, mask=4'b0111, handshakes on channels 0,2 at cycle 20 and channel 1 at cycle 23 → stays RELEASE until 23, COLLECT at 24, count+1.
- timeout_i=5, mask=4'b1111, barriers on channels 0–2 from cycle 10, channel 3 silent → timeout_o pulse at cycle 15; timeout_chan_o=4'b1000; synch_en_o=4'b0111 at 16; RELEASE follows; clr_i → timeout_chan_o=0 and synch_en_o=1111 after the next latch.
- ctrl_en_i dropped mid-RELEASE → fwd_barrier_o held until handshake, then IDLE with synch_en_o=0; async reset asserted mid-RELEASE → all outputs 0 immediately, barrier_cnt_o=0.
- mask=0 with barrier_i toggling → remains in COLLECT, synch_en_o=0, no timeout pulse, busy_o=0.

Source files
------------

// File: rtl/evt_barrier_ctrl.sv
// Barrier round sequencer for an N-channel event-stream synchronizer.
// Collects EVT_TIME barriers, then releases the leader or all channels.
module evt_barrier_ctrl #(
  parameter int N  = 4,
  parameter int TW = 16,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ctrl_en_i,
  input  logic [N-1:0]  chan_mask_i,
  input  logic          fwd_all_i,
  input  logic [TW-1:0] timeout_i,
  input  logic          clr_i,
  input  logic [N-1:0]  barrier_i,
  input  logic [N-1:0]  barrier_hs_i,
  output logic [N-1:0]  synch_en_o,
  output logic [N-1:0]  fwd_barrier_o,
  output logic [CW-1:0] barrier_cnt_o,
  output logic          timeout_o,
  output logic [N-1:0]  timeout_chan_o,
  output logic          busy_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NL = (PW+1)'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] lead_q, lead_d;
  logic [N-1:0]  act_q, act_d;
  logic [N-1:0]  drop_q, drop_d;
  logic [N-1:0]  done_q, done_d;
  logic          fall_q, fall_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] bcnt_q, bcnt_d;

  logic [N-1:0]  arr;
  logic [N-1:0]  fset;
  logic [N-1:0]  hs_f;
  logic [N-1:0]  lost;
  logic [N-1:0]  relatch;
  logic          in_col;
  logic          in_rel;
  logic          rel_ok;
  logic          rel_done;
  logic          tmo;

  // First set bit of m, scanning cyclically upward from p.
  function automatic logic [PW-1:0] pick(
    input logic [N-1:0]  m,
    input logic [PW-1:0] p
  );
    logic [PW-1:0] r;
    logic [PW:0]   s;
    logic          f;
    r = p;
    f = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, p} + (PW+1)'(i);
      if (s >= NL) s = s - NL;
      if (!f && m[s[PW-1:0]]) begin
        f = 1'b1;
        r = s[PW-1:0];
      end
    end
    return r;
  endfunction

  assign in_col   = (state_q == S_COLLECT);
  assign in_rel   = (state_q == S_RELEASE);
  assign arr      = barrier_i & act_q;
  assign lost     = act_q & ~arr;
  assign rel_ok   = (arr == act_q) && (act_q != '0);
  assign fset     = fall_q ? act_q : (N'(1) << lead_q);
  assign hs_f     = barrier_hs_i & fset;
  assign rel_done = ((done_q | hs_f) == fset);

  assign tmo = in_col && ctrl_en_i && (timeout_i != '0) &&
               (tcnt_q == timeout_i) && !rel_ok;

  // A timeout in the same cycle as clr_i still drops its channels.
  assign drop_d  = (clr_i ? '0 : drop_q) | (tmo ? lost : '0);
  assign relatch = chan_mask_i & ~drop_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lead_d  = lead_q;
    act_d   = act_q;
    done_d  = done_q;
    fall_d  = fall_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        done_d = '0;
        if (ctrl_en_i) begin
          state_d = S_COLLECT;
          act_d   = relatch;
        end
      end
      S_COLLECT: begin
        if (!ctrl_en_i) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else if (rel_ok) begin
          state_d = S_RELEASE;
          lead_d  = pick(act_q, ptr_q);
          fall_d  = fwd_all_i;
          done_d  = '0;
          tcnt_d  = '0;
        end else if (tmo) begin
          act_d  = arr;
          tcnt_d = '0;
        end else if (arr == '0) begin
          tcnt_d = '0;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_RELEASE: begin
        done_d = done_q | hs_f;
        if (rel_done) begin
          bcnt_d  = bcnt_q + CW'(1);
          ptr_d   = (lead_q == PW'(N - 1)) ? '0 : lead_q + PW'(1);
          done_d  = '0;
          act_d   = relatch;
          state_d = ctrl_en_i ? S_COLLECT : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lead_q  <= '0;
      act_q   <= '0;
      drop_q  <= '0;
      done_q  <= '0;
      fall_q  <= 1'b0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lead_q  <= lead_d;
      act_q   <= act_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      fall_q  <= fall_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign synch_en_o     = (in_col || in_rel) ? act_q : '0;
  assign fwd_barrier_o  = in_rel ? fset : '0;
  assign barrier_cnt_o  = bcnt_q;
  assign timeout_o      = tmo;
  assign timeout_chan_o = drop_q;
  assign busy_o         = in_rel || (in_col && (arr != '0));

endmodule
